// File: rtl/keypad_bus_master_if.sv
// rtl/keypad_bus_master_if.sv - CPU request, peripheral bus and key FIFO signal bundle for keypad_bus_master
interface keypad_bus_master_if;
    // CPU request side
    logic       cpu_req;
    logic       cpu_we;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ready;
    logic [7:0] cpu_rdata;

    // Peripheral bus side
    logic [3:0] address;
    logic [7:0] din;
    logic       writeEnable;
    logic [7:0] dout;

    // Buffered key codes
    logic       key_valid;
    logic [7:0] key_data;
    logic       key_pop;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dout, key_pop,
        output cpu_ready, cpu_rdata, address, din, writeEnable, key_valid, key_data
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, dout, key_pop,
        input  cpu_ready, cpu_rdata, address, din, writeEnable, key_valid, key_data
    );
endinterface

// File: rtl/keypad_bus_master.sv
// rtl/keypad_bus_master.sv - CPU-to-peripheral bus bridge; key autopoll and FIFO built when KEYPAD_AUTOPOLL_EN is defined
module keypad_bus_master #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         POLL_DIV   = 1000,
    parameter logic [3:0] KEY_ADDR   = 4'h0,
    parameter logic [3:0] IDLE_ADDR  = 4'hF
) (
    input logic                 clk,
    input logic                 reset,
    keypad_bus_master_if.master bus
);

`ifdef KEYPAD_AUTOPOLL_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_DONE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_PL_ISSUE,
        S_PL_WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_DONE,
        S_RD_ISSUE,
        S_RD_WAIT
    } state_t;
`endif

    state_t state;

    // The request is still held high while cpu_ready pulses; ignoring it in
    // that cycle keeps one request from being accepted twice.
    logic cpu_take;
    assign cpu_take = bus.cpu_req && !bus.cpu_ready;

`ifdef KEYPAD_AUTOPOLL_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(POLL_DIV);
    localparam logic [CW-1:0] POLL_TERM = CW'(POLL_DIV - 1);

    logic [CW-1:0] poll_cnt;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          poll_start;
    logic          key_push;
    logic          key_pop_eff;

    // The extra pointer bit separates full (same slot, different lap) from empty.
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A due poll only goes out from IDLE with no CPU work pending and room to
    // store the result; otherwise it simply waits at terminal count.
    assign poll_start  = (state == S_IDLE) && !cpu_take && (poll_cnt == POLL_TERM) && !fifo_full;

    // A zero code means no key was pressed, so it is never buffered.
    assign key_push    = (state == S_PL_WAIT) && (bus.dout != 8'h00);
    assign key_pop_eff = bus.key_pop && !fifo_empty;

    assign bus.key_valid = !fifo_empty;
    assign bus.key_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[AW-1:0]];

    // Poll interval counter: free-running, parks at terminal count until a poll issues.
    always_ff @(posedge clk) begin
        if (!reset) begin
            poll_cnt <= '0;
        end else if (poll_start) begin
            poll_cnt <= '0;
        end else if (poll_cnt != POLL_TERM) begin
            poll_cnt <= poll_cnt + CW'(1);
        end
    end

    // FIFO pointers: push and pop are independent, so a simultaneous pair keeps occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (key_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (key_pop_eff) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // FIFO storage: contents need no reset because key_data is masked while empty.
    always_ff @(posedge clk) begin
        if (reset && key_push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= bus.dout;
        end
    end
`else
    assign bus.key_valid = 1'b0;
    assign bus.key_data  = 8'h00;

    logic unused_cfg;
    assign unused_cfg = &{1'b0, bus.key_pop, FIFO_DEPTH[0], POLL_DIV[0], KEY_ADDR[0]};
`endif

    // Transfer sequencer: owns every bus output so each one is a register and
    // the key register address is never presented for more than one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_IDLE;
            bus.address     <= IDLE_ADDR;
            bus.din         <= 8'h00;
            bus.writeEnable <= 1'b0;
            bus.cpu_ready   <= 1'b0;
            bus.cpu_rdata   <= 8'h00;
        end else begin
            bus.cpu_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_take) begin
                        bus.address <= bus.cpu_addr;
                        if (bus.cpu_we) begin
                            bus.din         <= bus.cpu_wdata;
                            bus.writeEnable <= 1'b1;
                            state           <= S_WR;
                        end else begin
                            state <= S_RD_ISSUE;
                        end
                    end
`ifdef KEYPAD_AUTOPOLL_EN
                    else if (poll_start) begin
                        bus.address <= KEY_ADDR;
                        state       <= S_PL_ISSUE;
                    end
`endif
                end

                S_WR: begin
                    bus.address     <= IDLE_ADDR;
                    bus.writeEnable <= 1'b0;
                    bus.cpu_ready   <= 1'b1;
                    state           <= S_DONE;
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                // The peripheral registers dout, so data for this address
                // appears one cycle after the address is withdrawn.
                S_RD_ISSUE: begin
                    bus.address <= IDLE_ADDR;
                    state       <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    bus.cpu_rdata <= bus.dout;
                    bus.cpu_ready <= 1'b1;
                    state         <= S_IDLE;
                end

`ifdef KEYPAD_AUTOPOLL_EN
                S_PL_ISSUE: begin
                    bus.address <= IDLE_ADDR;
                    state       <= S_PL_WAIT;
                end

                S_PL_WAIT: begin
                    state <= S_IDLE;
                end
`endif

                default: begin
                    bus.address     <= IDLE_ADDR;
                    bus.writeEnable <= 1'b0;
                    state           <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_bus_master.sv
// tb/tb_keypad_bus_master.sv - self-checking bench for keypad_bus_master with a registered peripheral model
module tb_keypad_bus_master;
    localparam logic [3:0] KEY_ADDR  = 4'h0;
    localparam logic [3:0] IDLE_ADDR = 4'hF;
`ifdef KEYPAD_AUTOPOLL_EN
    localparam int MAX_ACC = 3;
`else
    localparam int MAX_ACC = 1;
`endif

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keypad_bus_master_if bus_i ();

    keypad_bus_master #(
        .FIFO_DEPTH(4),
        .POLL_DIV  (8),
        .KEY_ADDR  (KEY_ADDR),
        .IDLE_ADDR (IDLE_ADDR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_i)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] periph_regs [16];
    logic [7:0] exp_regs    [16];
    logic [7:0] key_q    [$];
    logic [7:0] exp_keys [$];
    logic [3:0] prev_addr   = IDLE_ADDR;
    logic       prev_we     = 1'b0;
    logic [7:0] prev_din    = 8'h00;
    int         key_cycles  = 0;
    logic [7:0] last_rdata  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: peripheral reacts to last cycle's bus as a registered slave would.
    task automatic step();
        @(posedge clk);
        #1;
        if (prev_we) periph_regs[prev_addr] = prev_din;
        if (prev_addr == KEY_ADDR) begin
            if (key_q.size() > 0) bus_i.dout = key_q.pop_front();
            else bus_i.dout = 8'h00;
        end else if (prev_addr == IDLE_ADDR) begin
            bus_i.dout = 8'($urandom);
        end else begin
            bus_i.dout = periph_regs[prev_addr];
        end
        if (bus_i.address == KEY_ADDR) begin
            key_cycles++;
            check("key_addr_single_cycle", 32'(prev_addr == KEY_ADDR), 0);
        end
        prev_addr = bus_i.address;
        prev_we   = bus_i.writeEnable;
        prev_din  = bus_i.din;
    endtask

    task automatic cpu_txn(input logic we, input logic [3:0] addr, input logic [7:0] wdata,
                           input logic [7:0] exp_rdata, output int acc);
        int t, rdy, addr_cycles, we_cycles;
        logic [7:0] din_at, rdata_at;
        logic [3:0] addr_at_rdy;
        logic       we_at_acc;
        bus_i.cpu_req   = 1'b1;
        bus_i.cpu_we    = we;
        bus_i.cpu_addr  = addr;
        bus_i.cpu_wdata = wdata;
        t = 0; acc = -1; rdy = -1; addr_cycles = 0; we_cycles = 0;
        din_at = 0; rdata_at = 0; addr_at_rdy = 0; we_at_acc = 0;
        while (rdy < 0 && t < 20) begin
            step();
            t++;
            if (bus_i.writeEnable) we_cycles++;
            if (bus_i.address == addr) begin
                addr_cycles++;
                if (acc < 0) begin
                    acc = t;
                    din_at = bus_i.din;
                    we_at_acc = bus_i.writeEnable;
                end
            end
            if (bus_i.cpu_ready) begin
                rdy = t;
                addr_at_rdy = bus_i.address;
                rdata_at = bus_i.cpu_rdata;
            end
        end
        bus_i.cpu_req = 1'b0;
        check("ready_seen", 32'(rdy > 0), 1);
        check("accept_latency", 32'(acc >= 1 && acc <= MAX_ACC), 1);
        check("ready_latency", rdy - acc, we ? 1 : 2);
        check("addr_cycles", addr_cycles, 1);
        check("ready_bus_idle", addr_at_rdy, IDLE_ADDR);
        if (we) begin
            check("we_cycles", we_cycles, 1);
            check("we_with_addr", we_at_acc, 1);
            check("din", din_at, wdata);
        end else begin
            check("we_cycles_rd", we_cycles, 0);
            check("rdata", rdata_at, exp_rdata);
        end
        step();
        check("ready_pulse", bus_i.cpu_ready, 0);
    endtask

    task automatic pop_check();
        check("key_order", bus_i.key_data, (exp_keys.size() > 0) ? exp_keys[0] : 8'h00);
        if (exp_keys.size() > 0) void'(exp_keys.pop_front());
        bus_i.key_pop = 1'b1;
        step();
        bus_i.key_pop = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_keys.size() > 0; i++) begin
            if (bus_i.key_valid) pop_check();
            else step();
        end
        check("drain_done", exp_keys.size(), 0);
        check("drain_periph", key_q.size(), 0);
    endtask

    initial begin
        vec_t tbl[10];
        logic [7:0] k, d, e;
        logic [3:0] a;
        logic       we;
        int         acc, found;

        tbl[0] = '{1'b0, 4'h4, 8'h00, 8'h5A};
        tbl[1] = '{1'b1, 4'h7, 8'hC3, 8'h00};
        tbl[2] = '{1'b0, 4'h7, 8'h00, 8'hC3};
        tbl[3] = '{1'b1, 4'h4, 8'hA5, 8'h00};
        tbl[4] = '{1'b0, 4'h4, 8'h00, 8'hA5};
        tbl[5] = '{1'b1, 4'h1, 8'hFF, 8'h00};
        tbl[6] = '{1'b0, 4'h1, 8'h00, 8'hFF};
        tbl[7] = '{1'b0, 4'h2, 8'h00, 8'hB2};
        tbl[8] = '{1'b1, 4'hE, 8'h01, 8'h00};
        tbl[9] = '{1'b0, 4'hE, 8'h00, 8'h01};

        for (int i = 0; i < 16; i++) begin
            periph_regs[i] = {4'hB, 4'(i)};
            exp_regs[i]    = {4'hB, 4'(i)};
        end
        reset = 1'b0;
        bus_i.cpu_req = 1'b0; bus_i.cpu_we = 1'b0; bus_i.cpu_addr = 4'h0;
        bus_i.cpu_wdata = 8'h00; bus_i.dout = 8'h00; bus_i.key_pop = 1'b0;

        repeat (3) step();
        check("rst_address", bus_i.address, IDLE_ADDR);
        check("rst_din", bus_i.din, 0);
        check("rst_we", bus_i.writeEnable, 0);
        check("rst_ready", bus_i.cpu_ready, 0);
        check("rst_rdata", bus_i.cpu_rdata, 0);
        check("rst_key_valid", bus_i.key_valid, 0);
        check("rst_key_data", bus_i.key_data, 0);
        reset = 1'b1;

        // Key register read passes straight through to the CPU
        key_q.push_back(8'h31);
        cpu_txn(1'b0, KEY_ADDR, 8'h00, 8'h31, acc);
        check("key_read_accept", acc, 1);
        check("key_read_not_buffered", bus_i.key_valid, 0);
        cpu_txn(1'b1, 4'h4, 8'h5A, 8'h00, acc);
        exp_regs[4] = 8'h5A;

        for (int i = 0; i < 10; i++) begin
            cpu_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, acc);
            if (tbl[i].we) exp_regs[tbl[i].addr] = tbl[i].wdata;
            else last_rdata = tbl[i].exp_rdata;
        end

        // Reset while a read waits for data: aborted, nothing reported
        bus_i.cpu_req = 1'b1; bus_i.cpu_we = 1'b0; bus_i.cpu_addr = 4'h7;
        found = 0;
        for (int i = 0; i < 6 && found == 0; i++) begin
            step();
            if (bus_i.address == 4'h7) found = 1;
        end
        check("abort_read_issued", found, 1);
        step();
        check("abort_rd_wait_idle", bus_i.address, IDLE_ADDR);
        reset = 1'b0;
        step();
        check("abort_ready", bus_i.cpu_ready, 0);
        check("abort_address", bus_i.address, IDLE_ADDR);
        check("abort_we", bus_i.writeEnable, 0);
        check("abort_din", bus_i.din, 0);
        check("abort_rdata", bus_i.cpu_rdata, 0);
        check("abort_key_valid", bus_i.key_valid, 0);
        bus_i.cpu_req = 1'b0;
        reset = 1'b1;
        step();
        check("abort_no_late_ready", bus_i.cpu_ready, 0);
        last_rdata = 8'h00;

`ifdef KEYPAD_AUTOPOLL_EN
        // Two keys polled into the FIFO in arrival order
        key_q.push_back(8'h11); key_q.push_back(8'h22);
        exp_keys.push_back(8'h11); exp_keys.push_back(8'h22);
        repeat (40) step();
        check("poll_key_valid", bus_i.key_valid, 1);
        check("poll_key_data", bus_i.key_data, 8'h11);
        check("poll_periph_empty", key_q.size(), 0);
        pop_check();
        check("pop1_valid", bus_i.key_valid, 1);
        check("pop1_data", bus_i.key_data, 8'h22);
        pop_check();
        check("pop2_valid", bus_i.key_valid, 0);
        key_cycles = 0;
        repeat (30) step();
        check("zero_polls_seen", 32'(key_cycles > 0), 1);
        check("zero_polls_no_push", bus_i.key_valid, 0);

        // Full FIFO suspends polling; one pop lets exactly one more key in
        for (int i = 1; i <= 6; i++) begin
            k = 8'hA0 + 8'(i);
            key_q.push_back(k);
            exp_keys.push_back(k);
        end
        repeat (80) step();
        check("full_periph_left", key_q.size(), 2);
        key_cycles = 0;
        repeat (40) step();
        check("full_no_polls", key_cycles, 0);
        pop_check();
        key_cycles = 0;
        repeat (20) step();
        check("resume_polls", 32'(key_cycles > 0), 1);
        check("resume_periph_left", key_q.size(), 1);
        drain();

        // CPU request on the poll-due cycle wins; the poll follows
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (bus_i.address == KEY_ADDR) found = 1;
        end
        check("poll_sync", found, 1);
        repeat (7) step();
        cpu_txn(1'b1, 4'h9, 8'h3C, 8'h00, acc);
        exp_regs[9] = 8'h3C;
        check("cpu_beats_poll", acc, 1);
        step();
        check("poll_after_cpu", bus_i.address, KEY_ADDR);
`endif

        for (int n = 0; n < 60; n++) begin
            if (($urandom % 4) == 0 && exp_keys.size() < 6) begin
                k = 8'($urandom_range(1, 255));
                key_q.push_back(k);
                exp_keys.push_back(k);
            end
            we = 1'($urandom % 2);
            if (we) begin
                a = 4'($urandom_range(1, 14));
                d = 8'($urandom);
                cpu_txn(1'b1, a, d, 8'h00, acc);
                exp_regs[a] = d;
                check("rdata_held", bus_i.cpu_rdata, last_rdata);
            end else begin
`ifdef KEYPAD_AUTOPOLL_EN
                a = 4'($urandom_range(1, 14));
`else
                a = 4'($urandom_range(0, 14));
`endif
                if (a == KEY_ADDR) begin
                    e = 8'h00;
                    if (exp_keys.size() > 0) e = exp_keys.pop_front();
                end else begin
                    e = exp_regs[a];
                end
                cpu_txn(1'b0, a, 8'h00, e, acc);
                last_rdata = e;
            end
`ifdef KEYPAD_AUTOPOLL_EN
            if (bus_i.key_valid && ($urandom % 2) == 0) pop_check();
`endif
        end

`ifdef KEYPAD_AUTOPOLL_EN
        drain();
`else
        bus_i.key_pop = 1'b1;
        step();
        check("bridge_key_valid", bus_i.key_valid, 0);
        check("bridge_key_data", bus_i.key_data, 0);
        bus_i.key_pop = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
